// File: rtl/uci_pkg.sv
// Shared definitions for the multi-channel UCI transmit path: newline byte,
// arbitration modes, transmitter states and an index-width helper.
package uci_pkg;

    localparam logic [7:0] NEWLINE = 8'h0A;

    typedef enum logic {
        ARB_FIXED = 1'b0,
        ARB_RR    = 1'b1
    } arb_mode_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_NL   = 2'd2
    } tx_state_t;

    // Index width that never collapses to zero bits for a single channel.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uci_rr_arbiter.sv
// One-hot channel arbiter with fixed-priority or round-robin search; the
// round-robin pointer moves past the granted channel on each advance strobe.
module uci_rr_arbiter
    import uci_pkg::*;
#(
    parameter int N_CH     = 4,
    parameter int ARB_MODE = 1,
    localparam int IDX_W   = clog2_min1(N_CH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_CH-1:0]  req,
    input  logic             advance,
    output logic [N_CH-1:0]  grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_valid
);

    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] start;

    assign start = (ARB_MODE == int'(ARB_RR)) ? ptr : '0;

    // Search wraps explicitly at N_CH since it need not be a power of two.
    always_comb begin
        int               cand;
        logic [IDX_W-1:0] cand_idx;
        cand        = 0;
        cand_idx    = '0;
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            cand = int'(start) + i;
            if (cand >= N_CH) begin
                cand = cand - N_CH;
            end
            cand_idx = IDX_W'(cand);
            if (!grant_valid && req[cand_idx]) begin
                grant[cand_idx] = 1'b1;
                grant_idx       = cand_idx;
                grant_valid     = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (advance && (ARB_MODE == int'(ARB_RR))) begin
            ptr <= (grant_idx == IDX_W'(N_CH - 1)) ? '0 : grant_idx + IDX_W'(1);
        end
    end

endmodule

// File: rtl/uci_tx_mux.sv
// Arbitrates N_CH NUL-terminated message sources onto one byte stream,
// appending a newline to every message and counting completed messages.
module uci_tx_mux
    import uci_pkg::*;
#(
    parameter int N_CH     = 4,
    parameter int MSG_LEN  = 64,
    parameter int ARB_MODE = 1,
    parameter int CNT_W    = 8,
    localparam int IDX_W   = clog2_min1(N_CH)
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic [N_CH*MSG_LEN*8-1:0] msg_in,
    input  logic [N_CH-1:0]           msg_valid,
    output logic [N_CH-1:0]           msg_ready,
    output logic [7:0]                char_out,
    output logic                      char_out_valid,
    input  logic                      char_out_ready,
    output logic                      busy,
    output logic [IDX_W-1:0]          active_ch,
    output logic [N_CH*CNT_W-1:0]     sent_cnt
);

    localparam int BUF_W = MSG_LEN * 8;
    localparam int BI_W  = $clog2(MSG_LEN + 1);

    tx_state_t        state, state_next;
    logic [BUF_W-1:0] shift_buf, buf_shifted;
    logic [BI_W-1:0]  byte_idx, byte_idx_inc;
    logic [CNT_W-1:0] cnt [N_CH];
    logic [BUF_W-1:0] ch_msg [N_CH];
    logic [N_CH-1:0]  grant;
    logic [IDX_W-1:0] grant_idx;
    logic             grant_valid;
    logic             can_accept, accept, first_empty, send_done;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        assign ch_msg[g]                     = msg_in[g*BUF_W +: BUF_W];
        assign sent_cnt[g*CNT_W +: CNT_W]    = cnt[g];
    end

    uci_rr_arbiter #(
        .N_CH     (N_CH),
        .ARB_MODE (ARB_MODE)
    ) u_arb (
        .clk         (clk_in),
        .rst         (rst_in),
        .req         (msg_valid),
        .advance     (accept),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    // A new message may be taken while idle or as the newline is handed off.
    assign can_accept   = !rst_in && ((state == ST_IDLE) || (state == ST_NL && char_out_ready));
    assign msg_ready    = can_accept ? grant : '0;
    assign accept       = can_accept && grant_valid;
    assign first_empty  = (ch_msg[grant_idx][7:0] == 8'h00);
    assign buf_shifted  = shift_buf >> 8;
    assign byte_idx_inc = byte_idx + BI_W'(1);
    assign send_done    = (buf_shifted[7:0] == 8'h00) || (byte_idx_inc == BI_W'(MSG_LEN));
    assign busy         = (state != ST_IDLE);

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next     = state;
        char_out       = 8'h00;
        char_out_valid = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_next = first_empty ? ST_NL : ST_SEND;
                end
            end
            ST_SEND: begin
                char_out       = shift_buf[7:0];
                char_out_valid = 1'b1;
                if (char_out_ready && send_done) begin
                    state_next = ST_NL;
                end
            end
            ST_NL: begin
                char_out       = NEWLINE;
                char_out_valid = 1'b1;
                if (char_out_ready) begin
                    state_next = accept ? (first_empty ? ST_NL : ST_SEND) : ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // The accept branch comes last so a back-to-back message overrides the
    // newline bookkeeping of the one that just finished.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            shift_buf <= '0;
            byte_idx  <= '0;
            active_ch <= '0;
            for (int i = 0; i < N_CH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            if (state == ST_SEND && char_out_ready) begin
                shift_buf <= buf_shifted;
                byte_idx  <= byte_idx_inc;
            end
            if (state == ST_NL && char_out_ready) begin
                active_ch <= '0;
                if (cnt[active_ch] != '1) begin
                    cnt[active_ch] <= cnt[active_ch] + CNT_W'(1);
                end
            end
            if (accept) begin
                shift_buf <= ch_msg[grant_idx];
                byte_idx  <= '0;
                active_ch <= grant_idx;
            end
        end
    end

endmodule

// File: tb/tb_uci_tx_mux.sv
// Scoreboard bench for uci_tx_mux: a round-robin instance (MSG_LEN=16) and a
// fixed-priority instance (MSG_LEN=8) share clock and reset.
module tb_uci_tx_mux;

    localparam int NCH    = 4;
    localparam int RR_LEN = 16;
    localparam int FP_LEN = 8;

    typedef struct packed {
        logic [3:0] ch;
        logic [7:0] b;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [NCH*RR_LEN*8-1:0] rr_msg;
    logic [NCH-1:0]          rr_valid, rr_ready;
    logic [7:0]              rr_char;
    logic                    rr_cvalid, rr_cready, rr_busy;
    logic [1:0]              rr_active;
    logic [NCH*8-1:0]        rr_cnt;

    logic [NCH*FP_LEN*8-1:0] fp_msg;
    logic [NCH-1:0]          fp_valid, fp_ready;
    logic [7:0]              fp_char;
    logic                    fp_cvalid, fp_cready, fp_busy;
    logic [1:0]              fp_active;
    logic [NCH*8-1:0]        fp_cnt;

    exp_t q_rr[$];
    exp_t q_fp[$];
    int   checks = 0;
    int   errors = 0;

    uci_tx_mux #(.N_CH(NCH), .MSG_LEN(RR_LEN), .ARB_MODE(1), .CNT_W(8)) dut_rr (
        .clk_in(clk), .rst_in(rst), .msg_in(rr_msg), .msg_valid(rr_valid),
        .msg_ready(rr_ready), .char_out(rr_char), .char_out_valid(rr_cvalid),
        .char_out_ready(rr_cready), .busy(rr_busy), .active_ch(rr_active),
        .sent_cnt(rr_cnt)
    );

    uci_tx_mux #(.N_CH(NCH), .MSG_LEN(FP_LEN), .ARB_MODE(0), .CNT_W(8)) dut_fp (
        .clk_in(clk), .rst_in(rst), .msg_in(fp_msg), .msg_valid(fp_valid),
        .msg_ready(fp_ready), .char_out(fp_char), .char_out_valid(fp_cvalid),
        .char_out_ready(fp_cready), .busy(fp_busy), .active_ch(fp_active),
        .sent_cnt(fp_cnt)
    );

    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic setMsg(input int inst, input int ch, input string s);
        int maxlen;
        logic [7:0] b;
        maxlen = (inst == 0) ? RR_LEN : FP_LEN;
        for (int i = 0; i < maxlen; i++) begin
            b = (i < s.len()) ? s[i] : 8'h00;
            if (inst == 0) rr_msg[(ch*RR_LEN + i)*8 +: 8] = b;
            else           fp_msg[(ch*FP_LEN + i)*8 +: 8] = b;
        end
    endtask

    task automatic pushExp(input int inst, input int ch, input logic [7:0] b);
        exp_t e;
        e.ch = 4'(ch);
        e.b  = b;
        if (inst == 0) q_rr.push_back(e);
        else           q_fp.push_back(e);
    endtask

    task automatic applyStimulus(input int inst, input int ch, input string s);
        int maxlen;
        maxlen = (inst == 0) ? RR_LEN : FP_LEN;
        setMsg(inst, ch, s);
        for (int i = 0; i < maxlen && i < s.len(); i++) begin
            if (s[i] == 8'h00) break;
            pushExp(inst, ch, s[i]);
        end
        pushExp(inst, ch, 8'h0A);
        if (inst == 0) rr_valid[ch] = 1'b1;
        else           fp_valid[ch] = 1'b1;
    endtask

    task automatic waitAccept(input int inst, input int ch);
        bit got;
        got = 1'b0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if ((inst == 0 && rr_ready[ch]) || (inst == 1 && fp_ready[ch])) begin
                got = 1'b1;
                break;
            end
        end
        checkOutput($sformatf("accept_i%0d_ch%0d", inst, ch), int'(got), 1);
        @(posedge clk);
        #1;
        if (inst == 0) rr_valid[ch] = 1'b0;
        else           fp_valid[ch] = 1'b0;
    endtask

    task automatic waitIdle(input int inst, output int cyc);
        cyc = 0;
        for (int k = 0; k < 400; k++) begin
            @(posedge clk);
            #1;
            cyc++;
            if (inst == 0 ? !rr_busy : !fp_busy) break;
        end
    endtask

    // Monitors: pop the scoreboard on every handshake and check stall stability.
    exp_t       rr_e, fp_e;
    logic       rr_pv, rr_pr, fp_pv, fp_pr;
    logic [7:0] rr_pc, fp_pc;

    always @(negedge clk) begin
        if (rst) begin
            rr_pv = 1'b0; rr_pr = 1'b0; rr_pc = 8'h00;
        end else begin
            if (rr_pv && !rr_pr) begin
                checkOutput("rr_stall_valid", int'(rr_cvalid), 1);
                checkOutput("rr_stall_char", int'(rr_char), int'(rr_pc));
            end
            if (rr_cvalid && rr_cready) begin
                if (q_rr.size() == 0) begin
                    checkOutput("rr_unexpected_byte", int'(rr_char), -1);
                end else begin
                    rr_e = q_rr.pop_front();
                    checkOutput("rr_byte", int'(rr_char), int'(rr_e.b));
                    checkOutput("rr_ch", int'(rr_active), int'(rr_e.ch));
                end
            end
            rr_pv = rr_cvalid; rr_pr = rr_cready; rr_pc = rr_char;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            fp_pv = 1'b0; fp_pr = 1'b0; fp_pc = 8'h00;
        end else begin
            if (fp_pv && !fp_pr) begin
                checkOutput("fp_stall_valid", int'(fp_cvalid), 1);
                checkOutput("fp_stall_char", int'(fp_char), int'(fp_pc));
            end
            if (fp_cvalid && fp_cready) begin
                if (q_fp.size() == 0) begin
                    checkOutput("fp_unexpected_byte", int'(fp_char), -1);
                end else begin
                    fp_e = q_fp.pop_front();
                    checkOutput("fp_byte", int'(fp_char), int'(fp_e.b));
                    checkOutput("fp_ch", int'(fp_active), int'(fp_e.ch));
                end
            end
            fp_pv = fp_cvalid; fp_pr = fp_cready; fp_pc = fp_char;
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int         cyc, n, last, idx;
        int         order[5];
        logic [3:0] pat;

        rr_msg = '0; rr_valid = '0; rr_cready = 1'b1;
        fp_msg = '0; fp_valid = '0; fp_cready = 1'b1;

        // Reset state, with every request raised so a leaky grant would show.
        rst = 1'b1;
        rr_valid = 4'hF;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_ready", int'(rr_ready), 0);
        checkOutput("rst_cvalid", int'(rr_cvalid), 0);
        checkOutput("rst_char", int'(rr_char), 0);
        checkOutput("rst_busy", int'(rr_busy), 0);
        checkOutput("rst_active", int'(rr_active), 0);
        checkOutput("rst_cnt", int'(rr_cnt), 0);
        checkOutput("rst_fp_cvalid", int'(fp_cvalid), 0);
        rr_valid = '0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Single message, ready held high; pointer moves to 1.
        applyStimulus(0, 0, "bestmove e2e4");
        waitAccept(0, 0);
        checkOutput("t1_first_valid", int'(rr_cvalid), 1);
        checkOutput("t1_first_char", int'(rr_char), 8'h62);
        waitIdle(0, cyc);
        checkOutput("t1_cycles", cyc, 14);
        checkOutput("t1_cnt0", int'(rr_cnt[7:0]), 1);

        // Backpressure with ready pattern 1,0,0,1; pointer moves to 2.
        applyStimulus(0, 1, "uciok");
        waitAccept(0, 1);
        pat = 4'b1001;
        for (int k = 0; k < 100; k++) begin
            rr_cready = pat[k % 4];
            @(posedge clk);
            #1;
            if (!rr_busy) break;
        end
        rr_cready = 1'b1;
        checkOutput("t2_idle", int'(rr_busy), 0);
        checkOutput("t2_cnt1", int'(rr_cnt[15:8]), 1);

        // All channels requesting: pointer is at 2, so service is 2,3,0,1,2.
        setMsg(0, 0, "0"); setMsg(0, 1, "1"); setMsg(0, 2, "2"); setMsg(0, 3, "3");
        order = '{2, 3, 0, 1, 2};
        rr_valid = 4'hF;
        n = 0; last = 0; cyc = 0;
        for (int k = 0; k < 100 && n < 5; k++) begin
            @(negedge clk);
            cyc++;
            if (rr_ready != '0) begin
                idx = 0;
                for (int j = 0; j < NCH; j++) if (rr_ready[j]) idx = j;
                checkOutput("t3_onehot", $countones(rr_ready), 1);
                checkOutput("t3_order", idx, order[n]);
                if (n > 0) begin
                    checkOutput("t3_nl_overlap", int'(rr_cvalid && rr_char == 8'h0A), 1);
                    checkOutput("t3_gap", cyc - last, 2);
                end
                pushExp(0, order[n], 8'(8'h30 + order[n]));
                pushExp(0, order[n], 8'h0A);
                last = cyc;
                n++;
            end
        end
        @(posedge clk);
        #1;
        rr_valid = '0;
        checkOutput("t3_accepts", n, 5);
        waitIdle(0, cyc);
        checkOutput("t3_cnt0", int'(rr_cnt[7:0]), 2);
        checkOutput("t3_cnt1", int'(rr_cnt[15:8]), 2);
        checkOutput("t3_cnt2", int'(rr_cnt[23:16]), 2);
        checkOutput("t3_cnt3", int'(rr_cnt[31:24]), 1);

        // Empty message emits only the newline.
        applyStimulus(0, 3, "");
        waitAccept(0, 3);
        waitIdle(0, cyc);
        checkOutput("t4_cycles", cyc, 1);
        checkOutput("t4_cnt3", int'(rr_cnt[31:24]), 2);

        // Full-length message with no NUL.
        applyStimulus(0, 1, "0123456789abcdef");
        waitAccept(0, 1);
        waitIdle(0, cyc);
        checkOutput("t5_cycles", cyc, 17);
        checkOutput("t5_cnt1", int'(rr_cnt[15:8]), 3);

        // Counter saturation: 260 further empty messages on channel 2.
        setMsg(0, 2, "");
        rr_valid[2] = 1'b1;
        n = 0;
        for (int k = 0; k < 600 && n < 260; k++) begin
            @(negedge clk);
            if (rr_ready[2]) begin
                pushExp(0, 2, 8'h0A);
                n++;
            end
        end
        @(posedge clk);
        #1;
        rr_valid[2] = 1'b0;
        waitIdle(0, cyc);
        checkOutput("t6_accepts", n, 260);
        checkOutput("t6_cnt2_sat", int'(rr_cnt[23:16]), 255);

        // Reset while the third byte of a message is on the bus.
        applyStimulus(0, 0, "info depth 5");
        waitAccept(0, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        checkOutput("t7_third_char", int'(rr_char), 8'h66);
        checkOutput("t7_remaining", q_rr.size(), 11);
        rst = 1'b1;
        #1;
        checkOutput("t7_drop_valid", int'(rr_cvalid), 0);
        checkOutput("t7_busy", int'(rr_busy), 0);
        checkOutput("t7_cnt_clear", int'(rr_cnt), 0);
        q_rr.delete();
        @(negedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        applyStimulus(0, 0, "info depth 5");
        waitAccept(0, 0);
        waitIdle(0, cyc);
        checkOutput("t7_cycles", cyc, 13);
        checkOutput("t7_cnt0", int'(rr_cnt[7:0]), 1);

        // Fixed priority: ch0 before ch2; ch2 payload changes after accept.
        applyStimulus(1, 0, "first");
        applyStimulus(1, 2, "second");
        waitAccept(1, 0);
        waitAccept(1, 2);
        setMsg(1, 2, "XXXXXXXX");
        waitIdle(1, cyc);
        checkOutput("f1_cycles", cyc, 7);
        checkOutput("f1_cnt0", int'(fp_cnt[7:0]), 1);
        checkOutput("f1_cnt2", int'(fp_cnt[23:16]), 1);

        // ch1 must still win over ch3; ch3 has a byte hidden after its NUL.
        applyStimulus(1, 1, "abcdefgh");
        applyStimulus(1, 3, "hi");
        fp_msg[(3*FP_LEN + 3)*8 +: 8] = 8'h7A;
        waitAccept(1, 1);
        waitAccept(1, 3);
        waitIdle(1, cyc);
        checkOutput("f2_cycles", cyc, 3);
        checkOutput("f2_cnt1", int'(fp_cnt[15:8]), 1);
        checkOutput("f2_cnt3", int'(fp_cnt[31:24]), 1);

        repeat (2) @(posedge clk);
        #1;
        checkOutput("rr_queue_empty", q_rr.size(), 0);
        checkOutput("fp_queue_empty", q_fp.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uci_tx_mux.md
Name: uci_tx_mux

Overview:
- Parametrised successor to the single-stream UCI output path. Arbitrates N_CH independent message sources (info, bestmove, id/uciok, debug echo, ...) onto one byte-wide UART TX stream.
- Each accepted message is emitted one byte per handshake. Emission stops at the first NUL or after MSG_LEN bytes, then a terminating newline (0x0A) is appended.
- Sits between the engine/handler message producers and the UART transmitter.

Parameters:
- N_CH, 4, number of message channels (1..16).
- MSG_LEN, 64, maximum payload bytes per message, excluding the newline.
- ARB_MODE, 1, arbitration mode: 0 = fixed priority (lowest index wins); 1 = round-robin.
- CNT_W, 8, width of each per-channel sent-message counter (saturating).

Ports:
- clk_in  in  1  clock.
- rst_in  in  1  reset, asynchronous, active-high.
- msg_in  in  N_CH x MSG_LEN x 8  per-channel packed message; byte [0] is sent first.
- msg_valid  in  N_CH  per-channel message valid.
- msg_ready  out  N_CH  per-channel accept; one-hot or zero.
- char_out  out  8  output byte.
- char_out_valid  out  1  output byte valid.
- char_out_ready  in  1  downstream ready.
- busy  out  1  high from message accept until the newline handshake completes.
- active_ch  out  $clog2(N_CH) (min 1)  channel currently being sent; 0 when idle.
- sent_cnt  out  N_CH x CNT_W  per-channel completed-message count, saturating at all-ones.

Behaviour:
- Reset (async assert, sync release): state IDLE; char_out=0; char_out_valid=0; busy=0; active_ch=0; sent_cnt all 0; msg_ready all 0; RR pointer = 0; internal buffer cleared.
- States: IDLE -> SEND -> NL -> IDLE.
- IDLE:
  - msg_ready is combinational: one-hot grant over msg_valid, and only while in IDLE.
  - Fixed-priority mode: grant goes to the lowest-index valid channel.
  - Round-robin mode: search starts at the RR pointer, wrapping modulo N_CH. On accept, the pointer becomes (granted+1) mod N_CH.
- Accept (msg_valid[g] & msg_ready[g] at cycle T):
  - Latch msg_in[g] into the shift buffer and set active_ch=g, busy=1.
  - If byte[0]≠0, go to SEND; otherwise go directly to NL (an empty message emits only the newline).
- SEND:
  - From T+1, char_out = buffer[0] and char_out_valid=1.
  - On each char_out_valid & char_out_ready handshake, shift the buffer down one byte and increment the byte index.
  - Go to NL when the next byte is 0 or the index reaches MSG_LEN.
  - char_out and char_out_valid must stay stable while valid & !ready. No bubbles while ready is held high: one byte per cycle.
- NL:
  - char_out=0x0A, char_out_valid=1.
  - On handshake: go to IDLE, clear busy, increment sent_cnt[active_ch] (saturating), set active_ch=0.
  - The next accept may occur in the same cycle as the newline handshake, with no idle cycle between messages. msg_ready is then evaluated as in IDLE.
- Latency and throughput:
  - Accept to first byte valid is 1 cycle.
  - A message of L payload bytes, with ready held high, occupies L+1 output cycles.
- Boundary conditions:
  - A full MSG_LEN message with no NUL sends exactly MSG_LEN bytes plus the newline.
  - Bytes after the first NUL are never sent.
  - msg_in and msg_valid changing after accept have no effect; the message is latched.
  - N_CH=1: the arbiter degenerates; both modes behave identically.
  - Reset mid-message: output is dropped immediately (char_out_valid=0 asynchronously). No partial newline is sent and the counters clear.
  - Simultaneous valid on all channels in round-robin mode: the service order is strictly cyclic.
- Widths: the byte index is $clog2(MSG_LEN+1) bits. The RR pointer wraps explicitly at N_CH, which need not be a power of two.

Decomposition:
- uci_pkg (shared) holds:
  - localparam NEWLINE = 8'h0A;
  - enum arb_mode_t {ARB_FIXED, ARB_RR};
  - the function clog2_min1.
- Sub-module uci_rr_arbiter (N_CH, ARB_MODE): req, advance strobe -> one-hot grant and index. It owns the RR pointer.
- Shift buffer and FSM live in uci_tx_mux.

Test Plan:
- Single channel, ch0 = "bestmove e2e4" (13 bytes, NUL-padded), ready held 1 -> 14 consecutive bytes "bestmove e2e4\n"; first valid at accept+1; sent_cnt[0]=1.
- Backpressure: ch1 = "uciok", ready toggled 1,0,0,1,... -> no byte repeated or skipped, char_out stable while stalled, stream = "uciok\n".
- ARB_MODE=1, all 4 channels valid continuously with 1-byte messages "0".."3" -> service order ch0,ch1,ch2,ch3,ch0; no idle cycle between the newline and the next accept.
- ARB_MODE=0, ch2 and ch0 valid together -> ch0 sent first, then ch2; the ch2 payload still matches its latched value after ch2 changes msg_in post-accept.
- Edge lengths: empty message (byte0=0) -> only 0x0A; MSG_LEN=8 with "abcdefgh" (no NUL) -> "abcdefgh\n"; a 255th message on a channel with CNT_W=8 -> sent_cnt stays 255.
- Assert rst_in at the 3rd byte of "info depth 5" -> char_out_valid drops in the same cycle; after release busy=0, sent_cnt=0, and the next message sends from byte 0.
